// File: rtl/av_test_pkg.sv
// Shared definitions for the audio/video test-pattern source.
//   mode_e     : pattern select encodings
//   bar_color  : colour-bar index -> {r,g,b} on/off mask
//   sync_level : applies sync polarity to an "in sync region" flag
package av_test_pkg;

  typedef enum logic [1:0] {
    ModeBars     = 2'd0,
    ModeChecker  = 2'd1,
    ModeGradient = 2'd2,
    ModeWhite    = 2'd3
  } mode_e;

  localparam int unsigned NumBars = 8;

  // Bar colours as {r,g,b} on/off, each bit expands to a full-scale component.
  localparam logic [2:0] BarWhite   = 3'b111;
  localparam logic [2:0] BarYellow  = 3'b110;
  localparam logic [2:0] BarCyan    = 3'b011;
  localparam logic [2:0] BarGreen   = 3'b010;
  localparam logic [2:0] BarMagenta = 3'b101;
  localparam logic [2:0] BarRed     = 3'b100;
  localparam logic [2:0] BarBlue    = 3'b001;
  localparam logic [2:0] BarBlack   = 3'b000;

  function automatic logic [2:0] bar_color(input logic [2:0] idx);
    logic [2:0] c;
    unique case (idx)
      3'd0:    c = BarWhite;
      3'd1:    c = BarYellow;
      3'd2:    c = BarCyan;
      3'd3:    c = BarGreen;
      3'd4:    c = BarMagenta;
      3'd5:    c = BarRed;
      3'd6:    c = BarBlue;
      default: c = BarBlack;
    endcase
    return c;
  endfunction

  function automatic logic sync_level(input logic in_sync, input logic active_low);
    return in_sync ^ active_low;
  endfunction

endpackage

// File: rtl/av_pattern_generator_if.sv
// Output bus of the test-pattern source: registered video timing/pixels and audio samples.
//   master : driven by av_pattern_generator
//   slave  : consumed by the downstream video/audio encoders
interface av_pattern_generator_if #(
  parameter int unsigned COLOR_BITS = 8,
  parameter int unsigned AUDIO_BITS = 16
);
  logic                         hsync;
  logic                         vsync;
  logic                         de;
  logic        [COLOR_BITS-1:0] red;
  logic        [COLOR_BITS-1:0] green;
  logic        [COLOR_BITS-1:0] blue;
  logic signed [AUDIO_BITS-1:0] audio_left;
  logic signed [AUDIO_BITS-1:0] audio_right;
  logic                         audio_valid;

  modport master (
    output hsync, vsync, de, red, green, blue, audio_left, audio_right, audio_valid
  );
  modport slave (
    input hsync, vsync, de, red, green, blue, audio_left, audio_right, audio_valid
  );
endinterface

// File: rtl/av_video_timing.sv
// Free-running raster timing: h/v counters, registered de/hsync/vsync.
//   clock, reset   : clock, synchronous active-high reset
//   h_o, v_o       : current counter position (unregistered view of state)
//   line_end_o     : h at last clock of line
//   frame_start_o  : counters at (0,0)
//   active_o       : current position inside active area
//   de_o/hsync_o/vsync_o : registered, one clock behind h_o/v_o
module av_video_timing
  import av_test_pkg::*;
#(
  parameter int unsigned H_ACTIVE        = 640,
  parameter int unsigned H_FRONT         = 16,
  parameter int unsigned H_SYNC          = 96,
  parameter int unsigned H_BACK          = 48,
  parameter int unsigned V_ACTIVE        = 480,
  parameter int unsigned V_FRONT         = 10,
  parameter int unsigned V_SYNC          = 2,
  parameter int unsigned V_BACK          = 33,
  parameter bit          SYNC_ACTIVE_LOW = 1'b1,
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK,
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK,
  localparam int unsigned HW      = $clog2(H_TOTAL),
  localparam int unsigned VW      = $clog2(V_TOTAL)
) (
  input  logic          clock,
  input  logic          reset,
  output logic [HW-1:0] h_o,
  output logic [VW-1:0] v_o,
  output logic          line_end_o,
  output logic          frame_start_o,
  output logic          active_o,
  output logic          de_o,
  output logic          hsync_o,
  output logic          vsync_o
);

  localparam logic [HW-1:0] HLast      = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] HActEnd    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HSyncFirst = HW'(H_ACTIVE + H_FRONT);
  localparam logic [HW-1:0] HSyncLast  = HW'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam logic [VW-1:0] VLast      = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] VActEnd    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VSyncFirst = VW'(V_ACTIVE + V_FRONT);
  localparam logic [VW-1:0] VSyncLast  = VW'(V_ACTIVE + V_FRONT + V_SYNC - 1);

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic          line_end, active, in_hsync, in_vsync;

  always_comb begin
    line_end = (h_q == HLast);
    h_d      = line_end ? '0 : h_q + 1'b1;
    v_d      = v_q;
    if (line_end) begin
      v_d = (v_q == VLast) ? '0 : v_q + 1'b1;
    end
    active   = (h_q < HActEnd) && (v_q < VActEnd);
    in_hsync = (h_q >= HSyncFirst) && (h_q <= HSyncLast);
    in_vsync = (v_q >= VSyncFirst) && (v_q <= VSyncLast);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      h_q     <= '0;
      v_q     <= '0;
      de_o    <= 1'b0;
      hsync_o <= sync_level(1'b0, SYNC_ACTIVE_LOW);
      vsync_o <= sync_level(1'b0, SYNC_ACTIVE_LOW);
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      de_o    <= active;
      hsync_o <= sync_level(in_hsync, SYNC_ACTIVE_LOW);
      vsync_o <= sync_level(in_vsync, SYNC_ACTIVE_LOW);
    end
  end

  assign h_o           = h_q;
  assign v_o           = v_q;
  assign line_end_o    = line_end;
  assign frame_start_o = (h_q == '0) && (v_q == '0);
  assign active_o      = active;

endmodule

// File: rtl/av_pattern_generator.sv
// Audio/video test-pattern source: raster timing, selectable video pattern,
// stereo square-wave tone on a fixed sample strobe, frame-rate blink.
//   clock, reset  : clock, synchronous active-high reset
//   mode          : 0 bars, 1 checkerboard, 2 gradient, 3 solid white (frame-latched)
//   audio_enable  : 1 = tone, 0 = zero samples (tone phase keeps running)
//   av            : video timing/pixels and audio samples (master modport)
//   blink         : toggles every BLINK_FRAMES frames
module av_pattern_generator
  import av_test_pkg::*;
#(
  parameter int unsigned H_ACTIVE        = 640,
  parameter int unsigned H_FRONT         = 16,
  parameter int unsigned H_SYNC          = 96,
  parameter int unsigned H_BACK          = 48,
  parameter int unsigned V_ACTIVE        = 480,
  parameter int unsigned V_FRONT         = 10,
  parameter int unsigned V_SYNC          = 2,
  parameter int unsigned V_BACK          = 33,
  parameter bit          SYNC_ACTIVE_LOW = 1'b1,
  parameter int unsigned COLOR_BITS      = 8,
  parameter int unsigned AUDIO_BITS      = 16,
  parameter int unsigned SAMPLE_DIV      = 525,
  parameter int unsigned TONE_HALF       = 24,
  parameter logic [AUDIO_BITS-1:0] AMPLITUDE = 16'h2000,
  parameter int unsigned BLINK_FRAMES    = 30
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [1:0]             mode,
  input  logic                   audio_enable,
  av_pattern_generator_if.master av,
  output logic                   blink
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);
  localparam int unsigned SW      = $clog2(SAMPLE_DIV + 1);
  localparam int unsigned TW      = $clog2(TONE_HALF + 1);
  localparam int unsigned FW      = $clog2(BLINK_FRAMES + 1);

  localparam logic [HW-1:0] BarLast = HW'(H_ACTIVE / NumBars - 1);
  localparam logic [SW-1:0] SLast   = SW'(SAMPLE_DIV - 1);
  localparam logic [TW-1:0] TLast   = TW'(TONE_HALF - 1);
  localparam logic [FW-1:0] FLast   = FW'(BLINK_FRAMES - 1);
  localparam logic [AUDIO_BITS-1:0] AmpNeg = (~AMPLITUDE) + 1'b1;

  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic          line_end, frame_start, active;

  av_video_timing #(
    .H_ACTIVE        (H_ACTIVE),
    .H_FRONT         (H_FRONT),
    .H_SYNC          (H_SYNC),
    .H_BACK          (H_BACK),
    .V_ACTIVE        (V_ACTIVE),
    .V_FRONT         (V_FRONT),
    .V_SYNC          (V_SYNC),
    .V_BACK          (V_BACK),
    .SYNC_ACTIVE_LOW (SYNC_ACTIVE_LOW)
  ) u_timing (
    .clock         (clock),
    .reset         (reset),
    .h_o           (h),
    .v_o           (v),
    .line_end_o    (line_end),
    .frame_start_o (frame_start),
    .active_o      (active),
    .de_o          (av.de),
    .hsync_o       (av.hsync),
    .vsync_o       (av.vsync)
  );

  // Pattern: mode is taken live on the frame-start cycle so pixel (0,0) already uses it.
  mode_e                  mode_q, mode_cur;
  logic [HW-1:0]          bar_cnt_q;
  logic [2:0]             bar_idx_q;
  logic [2:0]             bar_rgb;
  logic                   checker_white;
  logic [COLOR_BITS-1:0]  r_d, g_d, b_d;

  assign mode_cur      = frame_start ? mode_e'(mode) : mode_q;
  assign bar_rgb       = bar_color(bar_idx_q);
  assign checker_white = ((6'(h) ^ 6'(v)) & 6'h20) == 6'h00;

  always_comb begin
    r_d = '0;
    g_d = '0;
    b_d = '0;
    if (active) begin
      unique case (mode_cur)
        ModeBars: begin
          r_d = {COLOR_BITS{bar_rgb[2]}};
          g_d = {COLOR_BITS{bar_rgb[1]}};
          b_d = {COLOR_BITS{bar_rgb[0]}};
        end
        ModeChecker: begin
          r_d = {COLOR_BITS{checker_white}};
          g_d = r_d;
          b_d = r_d;
        end
        ModeGradient: begin
          r_d = COLOR_BITS'(h);
          g_d = r_d;
          b_d = r_d;
        end
        ModeWhite: begin
          r_d = '1;
          g_d = '1;
          b_d = '1;
        end
      endcase
    end
  end

  // Bar index tracks h with a width counter; the last bar saturates and absorbs the remainder.
  always_ff @(posedge clock) begin
    if (reset || line_end) begin
      bar_cnt_q <= '0;
      bar_idx_q <= '0;
    end else if (bar_cnt_q == BarLast) begin
      bar_cnt_q <= '0;
      if (bar_idx_q != 3'd7) bar_idx_q <= bar_idx_q + 1'b1;
    end else begin
      bar_cnt_q <= bar_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mode_q   <= ModeBars;
      av.red   <= '0;
      av.green <= '0;
      av.blue  <= '0;
    end else begin
      mode_q   <= mode_cur;
      av.red   <= r_d;
      av.green <= g_d;
      av.blue  <= b_d;
    end
  end

  // Audio: the right channel flips each time the left returns to positive.
  logic [SW-1:0] samp_q;
  logic [TW-1:0] tone_cnt_q;
  logic          left_neg_q, right_neg_q, strobe;

  assign strobe = (samp_q == SLast);

  always_ff @(posedge clock) begin
    if (reset) begin
      samp_q         <= '0;
      tone_cnt_q     <= '0;
      left_neg_q     <= 1'b0;
      right_neg_q    <= 1'b0;
      av.audio_valid <= 1'b0;
      av.audio_left  <= '0;
      av.audio_right <= '0;
    end else begin
      av.audio_valid <= strobe;
      samp_q         <= strobe ? '0 : samp_q + 1'b1;
      if (strobe) begin
        av.audio_left  <= audio_enable ? (left_neg_q ? AmpNeg : AMPLITUDE) : '0;
        av.audio_right <= audio_enable ? (right_neg_q ? AmpNeg : AMPLITUDE) : '0;
        if (tone_cnt_q == TLast) begin
          tone_cnt_q <= '0;
          left_neg_q <= ~left_neg_q;
          if (left_neg_q) right_neg_q <= ~right_neg_q;
        end else begin
          tone_cnt_q <= tone_cnt_q + 1'b1;
        end
      end
    end
  end

  // Blink: the first frame start after reset counts as frame 1.
  logic [FW-1:0] frame_cnt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      frame_cnt_q <= '0;
      blink       <= 1'b0;
    end else if (frame_start) begin
      if (frame_cnt_q == FLast) begin
        frame_cnt_q <= '0;
        blink       <= ~blink;
      end else begin
        frame_cnt_q <= frame_cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_av_pattern_generator.sv
module tb_av_pattern_generator;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset    = 1'b1;
  logic [1:0] mode_big = 2'd0;
  logic [1:0] mode_sm  = 2'd0;
  logic       en_big   = 1'b1;
  logic       en_sm    = 1'b1;
  logic       blink_big, blink_sm;

  av_pattern_generator_if #(.COLOR_BITS(8), .AUDIO_BITS(16)) big_if ();
  av_pattern_generator_if #(.COLOR_BITS(8), .AUDIO_BITS(16)) sm_if ();

  // Default 640x480 timing, used for line-level and audio-period checks.
  av_pattern_generator u_big (
    .clock        (clock),
    .reset        (reset),
    .mode         (mode_big),
    .audio_enable (en_big),
    .av           (big_if),
    .blink        (blink_big)
  );

  // Small raster (48x38 total, 40x34 active), active-high sync, fast audio and blink.
  av_pattern_generator #(
    .H_ACTIVE(40), .H_FRONT(2), .H_SYNC(4), .H_BACK(2),
    .V_ACTIVE(34), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .SYNC_ACTIVE_LOW(1'b0), .COLOR_BITS(8), .AUDIO_BITS(16),
    .SAMPLE_DIV(10), .TONE_HALF(3), .AMPLITUDE(16'h1234), .BLINK_FRAMES(2)
  ) u_sm (
    .clock        (clock),
    .reset        (reset),
    .mode         (mode_sm),
    .audio_enable (en_sm),
    .av           (sm_if),
    .blink        (blink_sm)
  );

  int checks = 0;
  int errors = 0;
  int n      = 0;  // clock edges since reset release
  bit mon    = 1'b0;
  int big_hs_cnt = 0, big_hs_first = -1;
  int sm_hs_cnt  = 0, sm_hs_first  = -1;
  int sm_vs_cnt  = 0, sm_vs_first  = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    n++;
    if (mon && n <= 800 && big_if.hsync === 1'b0) begin
      big_hs_cnt++;
      if (big_hs_first < 0) big_hs_first = n - 1;
    end
    if (mon && n <= 48 && sm_if.hsync === 1'b1) begin
      sm_hs_cnt++;
      if (sm_hs_first < 0) sm_hs_first = n - 1;
    end
    if (mon && n <= 1824 && sm_if.vsync === 1'b1) begin
      sm_vs_cnt++;
      if (sm_vs_first < 0) sm_vs_first = n;
    end
  endtask

  task automatic run_to(input int target);
    while (n < target) tick();
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_big_de",    big_if.de, 1'b0);
    chk("rst_big_rgb",   {big_if.red, big_if.green, big_if.blue}, 24'h0);
    chk("rst_big_hsync", big_if.hsync, 1'b1);
    chk("rst_big_vsync", big_if.vsync, 1'b1);
    chk("rst_big_valid", big_if.audio_valid, 1'b0);
    chk("rst_big_left",  {big_if.audio_left}, 16'h0);
    chk("rst_sm_hsync",  sm_if.hsync, 1'b0);
    chk("rst_sm_blink",  blink_sm, 1'b0);

    reset = 1'b0;
    n     = 0;
    mon   = 1'b1;
    chk("de_before_first_edge", big_if.de, 1'b0);

    run_to(1);
    chk("big_de_px0",   big_if.de, 1'b1);
    chk("big_rgb_px0",  {big_if.red, big_if.green, big_if.blue}, 24'hFFFFFF);
    chk("sm_rgb_px0",   {sm_if.red, sm_if.green, sm_if.blue}, 24'hFFFFFF);
    run_to(6);
    chk("sm_bar1_h5",   {sm_if.red, sm_if.green, sm_if.blue}, 24'hFFFF00);
    run_to(10);
    chk("sm_valid_k0",  sm_if.audio_valid, 1'b1);
    chk("sm_left_k0",   {sm_if.audio_left}, 16'h1234);
    chk("sm_right_k0",  {sm_if.audio_right}, 16'h1234);
    mode_sm = 2'd1;  // mid-frame: must wait for next frame
    run_to(15);
    chk("sm_valid_gap", sm_if.audio_valid, 1'b0);
    run_to(33);
    chk("sm_bar6_h32",  {sm_if.red, sm_if.green, sm_if.blue}, 24'h0000FF);
    run_to(40);
    chk("sm_bar7_de",   sm_if.de, 1'b1);
    chk("sm_bar7_rgb",  {sm_if.red, sm_if.green, sm_if.blue}, 24'h000000);
    chk("sm_left_k3",   {sm_if.audio_left}, 16'hEDCC);
    chk("sm_right_k3",  {sm_if.audio_right}, 16'h1234);
    run_to(41);
    chk("sm_de_h40",    sm_if.de, 1'b0);
    chk("sm_rgb_h40",   {sm_if.red, sm_if.green, sm_if.blue}, 24'h000000);
    run_to(54);
    chk("sm_still_bars", {sm_if.red, sm_if.green, sm_if.blue}, 24'hFFFF00);
    run_to(70);
    chk("sm_left_k6",   {sm_if.audio_left}, 16'h1234);
    chk("sm_right_k6",  {sm_if.audio_right}, 16'hEDCC);
    run_to(80);
    chk("big_bar0_h79", {big_if.red, big_if.green, big_if.blue}, 24'hFFFFFF);
    run_to(81);
    chk("big_bar1_h80", {big_if.red, big_if.green, big_if.blue}, 24'hFFFF00);
    run_to(100);
    chk("sm_left_k9",   {sm_if.audio_left}, 16'hEDCC);
    chk("sm_right_k9",  {sm_if.audio_right}, 16'hEDCC);
    en_sm = 1'b0;
    run_to(110);
    chk("sm_valid_off", sm_if.audio_valid, 1'b1);
    chk("sm_left_off",  {sm_if.audio_left}, 16'h0);
    chk("sm_right_off", {sm_if.audio_right}, 16'h0);
    en_sm = 1'b1;
    run_to(120);
    chk("sm_left_k11",  {sm_if.audio_left}, 16'hEDCC);
    chk("sm_right_k11", {sm_if.audio_right}, 16'hEDCC);
    run_to(160);
    chk("big_bar1_h159", {big_if.red, big_if.green, big_if.blue}, 24'hFFFF00);
    run_to(161);
    chk("big_bar2_h160", {big_if.red, big_if.green, big_if.blue}, 24'h00FFFF);
    run_to(524);
    chk("big_valid_524", big_if.audio_valid, 1'b0);
    run_to(525);
    chk("big_valid_525", big_if.audio_valid, 1'b1);
    chk("big_left_525",  {big_if.audio_left}, 16'h2000);
    chk("big_right_525", {big_if.audio_right}, 16'h2000);
    run_to(526);
    chk("big_valid_526", big_if.audio_valid, 1'b0);
    chk("big_left_hold", {big_if.audio_left}, 16'h2000);
    run_to(561);
    chk("big_bar7_de",   big_if.de, 1'b1);
    chk("big_bar7_rgb",  {big_if.red, big_if.green, big_if.blue}, 24'h000000);
    run_to(640);
    chk("big_h639_de",   big_if.de, 1'b1);
    run_to(641);
    chk("big_h640_de",   big_if.de, 1'b0);
    run_to(800);
    chk("big_hs_cnt",    big_hs_cnt, 96);
    chk("big_hs_first",  big_hs_first, 656);
    chk("sm_hs_cnt",     sm_hs_cnt, 4);
    chk("sm_hs_first",   sm_hs_first, 42);
    run_to(1049);
    chk("big_valid_1049", big_if.audio_valid, 1'b0);
    run_to(1050);
    chk("big_valid_1050", big_if.audio_valid, 1'b1);
    run_to(1824);
    chk("sm_de_lastpix", sm_if.de, 1'b0);
    chk("sm_blink_pre",  blink_sm, 1'b0);
    chk("sm_vs_cnt",     sm_vs_cnt, 96);
    chk("sm_vs_first",   sm_vs_first, 1681);
    run_to(1825);
    chk("sm_f1_de",      sm_if.de, 1'b1);
    chk("sm_f1_rgb00",   {sm_if.red, sm_if.green, sm_if.blue}, 24'hFFFFFF);
    chk("sm_blink_1",    blink_sm, 1'b1);
    run_to(1857);
    chk("sm_chk_32_0",   {sm_if.red, sm_if.green, sm_if.blue}, 24'h000000);
    chk("sm_chk_32_0de", sm_if.de, 1'b1);
    run_to(2000);
    mode_sm = 2'd2;
    run_to(3393);
    chk("sm_chk_32_32",  {sm_if.red, sm_if.green, sm_if.blue}, 24'hFFFFFF);
    run_to(3649);
    chk("sm_grad_0",     {sm_if.red, sm_if.green, sm_if.blue}, 24'h000000);
    chk("sm_grad_0de",   sm_if.de, 1'b1);
    run_to(3686);
    chk("sm_grad_37",    {sm_if.red, sm_if.green, sm_if.blue}, 24'h252525);
    run_to(3694);
    chk("sm_grad_blank", {sm_if.red, sm_if.green, sm_if.blue}, 24'h000000);
    chk("sm_hsync_h45",  sm_if.hsync, 1'b1);
    run_to(4000);
    mode_sm = 2'd3;
    run_to(5472);
    chk("sm_blink_hold", blink_sm, 1'b1);
    run_to(5473);
    chk("sm_blink_2",    blink_sm, 1'b0);
    chk("sm_white_0",    {sm_if.red, sm_if.green, sm_if.blue}, 24'hFFFFFF);
    run_to(5517);
    chk("sm_white_blank", {sm_if.red, sm_if.green, sm_if.blue}, 24'h000000);
    chk("big_blink",     blink_big, 1'b0);

    // Mid-line reset, then restart from (0,0).
    run_to(5530);
    reset   = 1'b1;
    mode_sm = 2'd2;
    tick();
    chk("mrst_big_de",    big_if.de, 1'b0);
    chk("mrst_big_hsync", big_if.hsync, 1'b1);
    chk("mrst_big_left",  {big_if.audio_left}, 16'h0);
    chk("mrst_sm_de",     sm_if.de, 1'b0);
    chk("mrst_sm_rgb",    {sm_if.red, sm_if.green, sm_if.blue}, 24'h000000);
    chk("mrst_sm_left",   {sm_if.audio_left}, 16'h0);
    chk("mrst_sm_valid",  sm_if.audio_valid, 1'b0);
    tick();
    mon   = 1'b0;
    reset = 1'b0;
    n     = 0;
    run_to(1);
    chk("rs_big_px0",   {big_if.red, big_if.green, big_if.blue}, 24'hFFFFFF);
    chk("rs_sm_de",     sm_if.de, 1'b1);
    chk("rs_sm_px0",    {sm_if.red, sm_if.green, sm_if.blue}, 24'h000000);
    run_to(4);
    chk("rs_sm_px3",    {sm_if.red, sm_if.green, sm_if.blue}, 24'h030303);
    run_to(9);
    chk("rs_sm_valid9", sm_if.audio_valid, 1'b0);
    run_to(10);
    chk("rs_sm_valid",  sm_if.audio_valid, 1'b1);
    chk("rs_sm_left",   {sm_if.audio_left}, 16'h1234);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
